div_bcd_converter: RTL and testbench

DIV_BCD_CONVERTER -- requirements
Module: div_bcd_converter

---
 rtl/div_pkg.sv | 15 +
 rtl/bcd_dabble_step.sv | 22 ++
 rtl/div_bcd_converter.sv | 122 ++++++++++++
 tb/tb_div_bcd_converter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared widths and FSM state encoding for the divider result BCD converter.
package div_pkg;
    localparam int QUOT_W     = 8;
    localparam int REM_W      = 7;
    localparam int BCD_DIGITS = 3;
    localparam int N_SHIFT    = 8;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = $clog2(N_SHIFT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;
endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
// the {bcd, binary} pair left by one bit.
module bcd_dabble_step
    import div_pkg::*;
(
    input  logic [BCD_W-1:0]  bcd_i,
    input  logic [QUOT_W-1:0] bin_i,
    output logic [BCD_W-1:0]  bcd_o,
    output logic [QUOT_W-1:0] bin_o
);
    logic [BCD_W-1:0] adj;

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            assign adj[4*gi +: 4] = (bcd_i[4*gi +: 4] >= 4'd5) ? (bcd_i[4*gi +: 4] + 4'd3)
                                                               : bcd_i[4*gi +: 4];
        end
    endgenerate

    assign bcd_o = {adj[BCD_W-2:0], bin_i[QUOT_W-1]};
    assign bin_o = {bin_i[QUOT_W-2:0], 1'b0};
endmodule

// File: rtl/div_bcd_converter.sv
// Converts a divider's quotient/remainder pair to BCD on each rising edge of
// valid, using an 8-step double-dabble sequence shared by both channels.
module div_bcd_converter
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [QUOT_W-1:0] quotient,
    input  logic [REM_W-1:0]  remainder,
    input  logic              valid,
    output logic [BCD_W-1:0]  q_bcd,
    output logic [BCD_W-1:0]  r_bcd,
    output logic              busy,
    output logic              done,
    output logic              missed
);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_SHIFT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [QUOT_W-1:0] q_bin_q, q_bin_d, r_bin_q, r_bin_d;
    logic [BCD_W-1:0]  q_acc_q, q_acc_d, r_acc_q, r_acc_d;
    logic [BCD_W-1:0]  q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;
    logic              missed_q, missed_d;
    logic              valid_dly_q;

    logic              capture;
    logic [BCD_W-1:0]  q_acc_step, r_acc_step;
    logic [QUOT_W-1:0] q_bin_step, r_bin_step;

    assign capture = valid & ~valid_dly_q;

    bcd_dabble_step u_step_quot (
        .bcd_i (q_acc_q),
        .bin_i (q_bin_q),
        .bcd_o (q_acc_step),
        .bin_o (q_bin_step)
    );

    bcd_dabble_step u_step_rem (
        .bcd_i (r_acc_q),
        .bin_i (r_bin_q),
        .bcd_o (r_acc_step),
        .bin_o (r_bin_step)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        q_bin_d  = q_bin_q;
        r_bin_d  = r_bin_q;
        q_acc_d  = q_acc_q;
        r_acc_d  = r_acc_q;
        q_bcd_d  = q_bcd_q;
        r_bcd_d  = r_bcd_q;
        // A new result arriving mid-conversion is dropped but remembered.
        missed_d = missed_q | (capture & (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    q_bin_d = quotient;
                    r_bin_d = {{(QUOT_W-REM_W){1'b0}}, remainder};
                    q_acc_d = '0;
                    r_acc_d = '0;
                    count_d = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                q_acc_d = q_acc_step;
                r_acc_d = r_acc_step;
                q_bin_d = q_bin_step;
                r_bin_d = r_bin_step;
                count_d = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    q_bcd_d = q_acc_step;
                    r_bcd_d = r_acc_step;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            q_bin_q     <= '0;
            r_bin_q     <= '0;
            q_acc_q     <= '0;
            r_acc_q     <= '0;
            q_bcd_q     <= '0;
            r_bcd_q     <= '0;
            missed_q    <= 1'b0;
            valid_dly_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            q_bin_q     <= q_bin_d;
            r_bin_q     <= r_bin_d;
            q_acc_q     <= q_acc_d;
            r_acc_q     <= r_acc_d;
            q_bcd_q     <= q_bcd_d;
            r_bcd_q     <= r_bcd_d;
            missed_q    <= missed_d;
            valid_dly_q <= valid;
        end
    end

    assign q_bcd  = q_bcd_q;
    assign r_bcd  = r_bcd_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign missed = missed_q;
endmodule

// File: tb/tb_div_bcd_converter.sv
// Scoreboard bench for div_bcd_converter: expected BCD pairs and completion
// cycles are queued at capture and retired when done pulses.
module tb_div_bcd_converter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  quotient = '0;
    logic [6:0]  remainder = '0;
    logic        valid = 1'b0;
    logic [11:0] q_bcd, r_bcd;
    logic        busy, done, missed;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [23:0] exp_res_q[$];
    int          exp_cyc_q[$];
    logic [23:0] mon_res;
    int          mon_cyc;

    div_bcd_converter dut (
        .clk       (clk),
        .reset     (reset),
        .quotient  (quotient),
        .remainder (remainder),
        .valid     (valid),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
        .busy      (busy),
        .done      (done),
        .missed    (missed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] bcd_ref(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Called at a falling edge; the capture edge is the next rising edge N,
    // and done is expected during the cycle after N+8.
    task automatic push_exp(input int q, input int r);
        exp_res_q.push_back({bcd_ref(q), bcd_ref(r)});
        exp_cyc_q.push_back(cyc + 9);
    endtask

    task automatic drive(input int q, input int r);
        quotient  = q[7:0];
        remainder = r[6:0];
        valid     = 1'b1;
        push_exp(q, r);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_res_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (exp_res_q.size() != 0) begin
            chk("drain_timeout", exp_res_q.size(), 0);
            exp_res_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic conv(input int q, input int r);
        @(negedge clk);
        drive(q, r);
        wait_drain();
        valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic conv_hold(input int q, input int r, input logic [11:0] pq, input logic [11:0] pr);
        @(negedge clk);
        drive(q, r);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("hold_q_bcd", q_bcd, pq);
            chk("hold_r_bcd", r_bcd, pr);
            chk("busy_during", busy, 1);
        end
        wait_drain();
        valid = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (exp_res_q.size() == 0) begin
                chk("spurious_done", done, 0);
            end else begin
                mon_res = exp_res_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                $display("txn cycle=%0d q_bcd=%03h r_bcd=%03h exp=%03h/%03h",
                         cyc, q_bcd, r_bcd, mon_res[23:12], mon_res[11:0]);
                chk("q_bcd", q_bcd, mon_res[23:12]);
                chk("r_bcd", r_bcd, mon_res[11:0]);
                chk("latency", cyc, mon_cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_q_bcd", q_bcd, 0);
        chk("rst_r_bcd", r_bcd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_missed", missed, 0);
        reset = 1'b0;
        @(negedge clk);

        // Maximum values; outputs hold reset value until completion.
        conv_hold(255, 127, 12'h000, 12'h000);
        // Zero, then a result whose predecessor must stay visible meanwhile.
        conv_hold(0, 0, 12'h255, 12'h127);
        conv_hold(100, 9, 12'h000, 12'h000);

        // Second valid rising edge three edges after capture.
        @(negedge clk);
        drive(12, 3);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        quotient = 8'd7;
        valid = 1'b1;
        wait_drain();
        chk("missed_set", missed, 1);
        valid = 1'b0;
        @(negedge clk);
        conv(9, 99);
        chk("missed_sticky", missed, 1);

        // Reset between edges N+4 and N+5, with valid high at release.
        @(negedge clk);
        drive(200, 64);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        exp_res_q.delete();
        exp_cyc_q.delete();
        #1;
        chk("abort_q_bcd", q_bcd, 0);
        chk("abort_r_bcd", r_bcd, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_missed", missed, 0);
        @(negedge clk);
        chk("abort_done_after", done, 0);
        quotient  = 8'd55;
        remainder = 7'd66;
        reset = 1'b0;
        push_exp(55, 66);
        wait_drain();
        valid = 1'b0;
        @(negedge clk);

        // Level-held valid: one conversion only.
        @(negedge clk);
        drive(42, 5);
        repeat (40) @(negedge clk);
        valid = 1'b0;
        wait_drain();
        repeat (12) @(negedge clk);
        chk("held_missed", missed, 0);

        // Full quotient and remainder ranges with varied partners.
        for (int q = 0; q < 256; q++) conv(q, (q * 53) % 128);
        for (int r = 0; r < 128; r++) conv((r * 37 + 11) % 256, r);
        wait_drain();
        chk("missed_end", missed, 0);
        chk("busy_end", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
